// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the simulation UART receiver model.
// Contents: parity mode enum, receiver state enum, bit-period helper.
package sim_uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned freq,
                                               input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sim_uart_line_buf.sv
// Line buffer for the simulation UART receiver.
// Collects error-free received words; a newline or a full buffer flushes it,
// and the count returns to 0 on the cycle after the flushing write.
// Optional macro: SIM_UART_RX_PRINT_EN -- prints each flushed line as ASCII
// (without the newline).
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   wr_i    in   write strobe (one cycle per stored word)
//   data_i  in   word to store
//   count_o out  characters currently held
module sim_uart_line_buf
  import sim_uart_pkg::*;
#(
  parameter int unsigned DataBitsSize = 8,
  parameter int unsigned BufferSize   = 128,
  parameter int unsigned CountW       = $clog2(BufferSize + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_i,
  input  logic [DataBitsSize-1:0] data_i,
  output logic [CountW-1:0]       count_o
);

  localparam logic [DataBitsSize-1:0] Newline = DataBitsSize'(8'h0A);

  logic [CountW-1:0] count_q, count_d;
  logic              flush_q, flush_d;

  always_comb begin
    count_d = count_q;
    flush_d = 1'b0;
    if (flush_q) begin
      count_d = '0;
    end else if (wr_i) begin
      count_d = count_q + CountW'(1);
      flush_d = (data_i == Newline) || (count_d == CountW'(BufferSize));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  assign count_o = count_q;

`ifdef SIM_UART_RX_PRINT_EN
  // The character storage only feeds the console print, so it exists only
  // when printing is compiled in; the count logic above is identical.
  localparam int unsigned IdxW = (BufferSize > 1) ? $clog2(BufferSize) : 1;

  logic [DataBitsSize-1:0] mem_q [BufferSize];
  logic                    last_nl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_nl_q <= 1'b0;
    end else if (wr_i && !flush_q) begin
      mem_q[count_q[IdxW-1:0]] <= data_i;
      last_nl_q                <= (data_i == Newline);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && flush_q) begin
      automatic string       line = "";
      automatic int unsigned n    = last_nl_q ? int'(count_q) - 1 : int'(count_q);
      for (int unsigned i = 0; i < n; i++) begin
        line = $sformatf("%s%c", line, mem_q[i]);
      end
      $display("%s", line);
    end
  end
`endif

endmodule

// File: rtl/sim_uart_rx.sv
// Simulation-side UART receiver model listening on the SoC uart_tx line.
// Deserialises frames (LSB first), checks parity and stop bits, and feeds
// error-free words into a line buffer.
// Optional macro: SIM_UART_RX_PRINT_EN -- console print of flushed lines and
// a warning for every errored frame.
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   rx_sig        in   serial line, idles high
//   rx_valid      out  one-cycle pulse on frame completion
//   rx_data       out  last received data word
//   parity_error  out  parity result of the last frame
//   frame_error   out  stop-bit result of the last frame
//   buf_count     out  characters held in the line buffer
module sim_uart_rx
  import sim_uart_pkg::*;
#(
  parameter int unsigned BaudRate     = 115200,
  parameter int unsigned ParityBit    = 0,
  parameter int unsigned DataBitsSize = 8,
  parameter int unsigned StopBitsSize = 1,
  parameter int unsigned BufferSize   = 128,
  parameter int unsigned ClockFreqHz  = 100000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_sig,
  output logic                               rx_valid,
  output logic [DataBitsSize-1:0]            rx_data,
  output logic                               parity_error,
  output logic                               frame_error,
  output logic [$clog2(BufferSize+1)-1:0]    buf_count
);

  localparam int unsigned ClksPerBit = clks_per_bit(ClockFreqHz, BaudRate);
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam parity_e     Mode       = (ParityBit == 1) ? PARITY_ODD  :
                                       (ParityBit == 2) ? PARITY_EVEN : PARITY_NONE;

  // Synchroniser plus one history flop for falling-edge detection.
  logic sync1_q, sync2_q, prev_q;
  logic rx_s;

  rx_state_e               state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [DataBitsSize-1:0] shift_q, shift_d;
  logic                    par_err_q, par_err_d;
  logic                    fr_err_q, fr_err_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [DataBitsSize-1:0] rx_data_q, rx_data_d;
  logic                    parity_error_q, parity_error_d;
  logic                    frame_error_q, frame_error_d;
  logic                    fe;

  assign rx_s = sync2_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    fr_err_d       = fr_err_q;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    fe             = fr_err_q | ~rx_s;

    unique case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HalfBit - 1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (cnt_q == ClksPerBit - 1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DataBitsSize-1:1]};
          if (bit_q == 4'(DataBitsSize - 1)) begin
            bit_d     = '0;
            par_err_d = 1'b0;
            fr_err_d  = 1'b0;
            state_d   = (Mode != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PARITY: begin
        if (cnt_q == ClksPerBit - 1) begin
          cnt_d     = '0;
          par_err_d = (Mode == PARITY_ODD) ? ~((^shift_q) ^ rx_s) : ((^shift_q) ^ rx_s);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (cnt_q == ClksPerBit - 1) begin
          cnt_d = '0;
          if (bit_q == 4'(StopBitsSize - 1)) begin
            // Completes mid-stop-bit so a back-to-back start edge is caught.
            rx_valid_d     = 1'b1;
            rx_data_d      = shift_q;
            parity_error_d = par_err_q;
            frame_error_d  = fe;
            bit_d          = '0;
            state_d        = IDLE;
          end else begin
            fr_err_d = fe;
            bit_d    = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      prev_q         <= 1'b1;
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      par_err_q      <= 1'b0;
      fr_err_q       <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      sync1_q        <= rx_sig;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      par_err_q      <= par_err_d;
      fr_err_q       <= fr_err_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;

  sim_uart_line_buf #(
    .DataBitsSize(DataBitsSize),
    .BufferSize  (BufferSize),
    .CountW      ($clog2(BufferSize + 1))
  ) u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_i   (rx_valid_q && !parity_error_q && !frame_error_q),
    .data_i (rx_data_q),
    .count_o(buf_count)
  );

`ifdef SIM_UART_RX_PRINT_EN
  always_ff @(posedge clk) begin
    if (!rst && rx_valid_q && (parity_error_q || frame_error_q)) begin
      $display("sim_uart_rx: warning: %s%s error, data 0x%0h",
               parity_error_q ? "parity " : "", frame_error_q ? "frame " : "", rx_data_q);
    end
  end
`endif

endmodule

// File: tb/tb_sim_uart_rx.sv
module tb_sim_uart_rx;
  import sim_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_l [3];
  logic       rx_line [3];
  logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2;
  logic [7:0] d0, d1, d2;
  logic [7:0] c0, c1;
  logic [2:0] c2;
  int         vcnt [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // dut0: 8N1, dut1: 8E1, dut2: 8N1 with a 4-character buffer.
  sim_uart_rx #(.BaudRate(100000), .ClockFreqHz(1000000), .ParityBit(0),
                .DataBitsSize(8), .StopBitsSize(1), .BufferSize(128)) dut0 (
    .clk(clk), .rst(rst_l[0]), .rx_sig(rx_line[0]), .rx_valid(v0), .rx_data(d0),
    .parity_error(pe0), .frame_error(fe0), .buf_count(c0));
  sim_uart_rx #(.BaudRate(100000), .ClockFreqHz(1000000), .ParityBit(2),
                .DataBitsSize(8), .StopBitsSize(1), .BufferSize(128)) dut1 (
    .clk(clk), .rst(rst_l[1]), .rx_sig(rx_line[1]), .rx_valid(v1), .rx_data(d1),
    .parity_error(pe1), .frame_error(fe1), .buf_count(c1));
  sim_uart_rx #(.BaudRate(100000), .ClockFreqHz(1000000), .ParityBit(0),
                .DataBitsSize(8), .StopBitsSize(1), .BufferSize(4)) dut2 (
    .clk(clk), .rst(rst_l[2]), .rx_sig(rx_line[2]), .rx_valid(v2), .rx_data(d2),
    .parity_error(pe2), .frame_error(fe2), .buf_count(c2));

  always @(posedge clk) begin
    if (v0) vcnt[0] <= vcnt[0] + 1;
    if (v1) vcnt[1] <= vcnt[1] + 1;
    if (v2) vcnt[2] <= vcnt[2] + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame at 10 clocks per bit, driven on falling edges.
  task automatic send(input int id, input logic [7:0] d, input bit has_par,
                      input bit par, input bit stop);
    @(negedge clk);
    rx_line[id] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line[id] = d[i];
      repeat (10) @(negedge clk);
    end
    if (has_par) begin
      rx_line[id] = par;
      repeat (10) @(negedge clk);
    end
    rx_line[id] = stop;
    repeat (10) @(negedge clk);
    rx_line[id] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] outs(input int id, input int sel);
    case (id)
      0: return (sel == 0) ? 32'(d0) : (sel == 1) ? 32'(pe0) : (sel == 2) ? 32'(fe0) : 32'(c0);
      1: return (sel == 0) ? 32'(d1) : (sel == 1) ? 32'(pe1) : (sel == 2) ? 32'(fe1) : 32'(c1);
      default: return (sel == 0) ? 32'(d2) : (sel == 1) ? 32'(pe2) : (sel == 2) ? 32'(fe2) : 32'(c2);
    endcase
  endfunction

  task automatic check_frame(input string tag, input int id, input int vbefore,
                             input logic [7:0] ed, input bit epe, input bit efe,
                             input int ecnt);
    check({tag, "_pulses"}, 32'(vcnt[id] - vbefore), 32'd1);
    check({tag, "_data"},   outs(id, 0), 32'(ed));
    check({tag, "_perr"},   outs(id, 1), 32'(epe));
    check({tag, "_ferr"},   outs(id, 2), 32'(efe));
    check({tag, "_count"},  outs(id, 3), 32'(ecnt));
  endtask

  // Reference line-buffer model: stored characters as a queue.
  logic [7:0] q0[$], q1[$];

  function automatic void model_push(inout logic [7:0] q[$], input logic [7:0] d,
                                     input int depth);
    q.push_back(d);
    if (d == 8'h0A || q.size() == depth) q.delete();
  endfunction

  initial begin
    logic [7:0] hi [3];
    int         vb;
    logic [7:0] d;
    bit         sb, pb, epe;

    for (int i = 0; i < 3; i++) begin
      rst_l[i]   = 1'b1;
      rx_line[i] = 1'b1;
      vcnt[i]    = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(v0), 32'd0);
    check("reset_data",  32'(d0), 32'd0);
    check("reset_perr",  32'(pe0), 32'd0);
    check("reset_ferr",  32'(fe0), 32'd0);
    check("reset_count", 32'(c0), 32'd0);
    for (int i = 0; i < 3; i++) rst_l[i] = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0x41
    vb = vcnt[0]; send(0, 8'h41, 0, 0, 1);
    model_push(q0, 8'h41, 128);
    check_frame("a41", 0, vb, 8'h41, 0, 0, q0.size());

    // "Hi\n": count 2, 3 -> flushed to 0
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      vb = vcnt[0]; send(0, hi[i], 0, 0, 1);
      model_push(q0, hi[i], 128);
      check_frame($sformatf("hi%0d", i), 0, vb, hi[i], 0, 0, q0.size());
    end

    // Start-bit glitch: 3 cycles low
    vb = vcnt[0];
    @(negedge clk); rx_line[0] = 1'b0;
    repeat (3) @(negedge clk); rx_line[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_pulses", 32'(vcnt[0] - vb), 32'd0);
    check("glitch_idle", 32'(dut0.state_q), 32'(IDLE));

    // Stop bit 0 on 0x55: flagged, not stored
    vb = vcnt[0]; send(0, 8'h55, 0, 0, 0);
    check_frame("stop0", 0, vb, 8'h55, 0, 1, q0.size());

    // Even parity 0x03: parity bit 1 is wrong, 0 is right
    vb = vcnt[1]; send(1, 8'h03, 1, 1, 1);
    check_frame("even_bad", 1, vb, 8'h03, 1, 0, q1.size());
    vb = vcnt[1]; send(1, 8'h03, 1, 0, 1);
    model_push(q1, 8'h03, 128);
    check_frame("even_ok", 1, vb, 8'h03, 0, 0, q1.size());

    // Buffer full flush at 4 characters
    for (int i = 0; i < 4; i++) begin
      vb = vcnt[2]; d = 8'h31 + 8'(i); send(2, d, 0, 0, 1);
      check_frame($sformatf("full%0d", i), 2, vb, d, 0, 0, (i == 3) ? 0 : i + 1);
    end

    // Reset mid-frame on the next frame
    vb = vcnt[2];
    @(negedge clk); rx_line[2] = 1'b0;
    repeat (10) @(negedge clk); rx_line[2] = 1'b1;
    repeat (10) @(negedge clk); rx_line[2] = 1'b0;
    repeat (15) @(negedge clk);
    rst_l[2] = 1'b1; rx_line[2] = 1'b1;
    repeat (3) @(negedge clk);
    rst_l[2] = 1'b0;
    repeat (120) @(negedge clk);
    check("rstmid_pulses", 32'(vcnt[2] - vb), 32'd0);
    check("rstmid_valid", 32'(v2), 32'd0);
    check("rstmid_data",  outs(2, 0), 32'd0);
    check("rstmid_perr",  outs(2, 1), 32'd0);
    check("rstmid_ferr",  outs(2, 2), 32'd0);
    check("rstmid_count", outs(2, 3), 32'd0);

    // Randomised 8N1 frames with occasional newline and bad stop bit
    for (int n = 0; n < 20; n++) begin
      d  = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      vb = vcnt[0]; send(0, d, 0, 0, sb);
      if (sb) model_push(q0, d, 128);
      check_frame($sformatf("rnd8n1_%0d", n), 0, vb, d, 0, !sb, q0.size());
    end

    // Randomised 8E1 frames: even parity means total ones (data + parity) is even
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      epe = (($countones(d) + int'(pb)) % 2) != 0;
      vb = vcnt[1]; send(1, d, 1, pb, 1);
      if (!epe) model_push(q1, d, 128);
      check_frame($sformatf("rnd8e1_%0d", n), 1, vb, d, epe, 0, q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
